// File: rtl/bip_pkg.sv
// Shared definitions for the BIP program sequencer: run-state encoding,
// command selection in priority order, and the default address width.
package bip_pkg;

    localparam int AB_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Commands listed highest priority first
    typedef enum logic [2:0] {
        CMD_HALT  = 3'd0,
        CMD_STALL = 3'd1,
        CMD_RET   = 3'd2,
        CMD_CALL  = 3'd3,
        CMD_JMP   = 3'd4,
        CMD_NEXT  = 3'd5
    } cmd_t;

    // Pick the winning command; losers in the same cycle are dropped
    function automatic cmd_t pick_cmd(
        input logic i_halt,
        input logic i_stall,
        input logic i_ret,
        input logic i_call,
        input logic i_jmp
    );
        if (i_halt)       return CMD_HALT;
        else if (i_stall) return CMD_STALL;
        else if (i_ret)   return CMD_RET;
        else if (i_call)  return CMD_CALL;
        else if (i_jmp)   return CMD_JMP;
        else              return CMD_NEXT;
    endfunction

endpackage

// File: rtl/bip_return_stack.sv
// LIFO of return addresses. Ports: clk, rst (sync, active-high),
// push/pop/din in; dout (top entry, combinational), level, full, empty out.
module bip_return_stack #(
    parameter int AB          = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic [AB-1:0]                      din,
    output logic [AB-1:0]                      dout,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   level,
    output logic                               full,
    output logic                               empty
);

    localparam int LW = $clog2(STACK_DEPTH + 1);

    logic [AB-1:0] r_mem [STACK_DEPTH];
    logic [LW-1:0] r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (int'(r_level) == STACK_DEPTH);
    assign empty     = (r_level == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else if (w_do_push) begin
            r_level <= r_level + LW'(1);
        end else if (w_do_pop) begin
            r_level <= r_level - LW'(1);
        end
    end

    // Contents need no reset; only entries below level are ever read
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_do_push && i == int'(r_level)) begin
                r_mem[i] <= din;
            end
        end
    end

    // Loop select avoids indexing the array with the wider level count
    always_comb begin
        dout = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (i == int'(r_level) - 1) begin
                dout = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// BIP program sequencer: IDLE/RUN/HALT control, Addr register, stall/jmp/call/ret.
// Ports: clk, rst, command inputs, jmp_addr in; Addr, running, halted, stk_err, stk_level out.
module program_sequencer
    import bip_pkg::*;
#(
    parameter int            AB          = AB_DEF,
    parameter logic [AB-1:0] RESET_ADDR  = '0,
    parameter int            STACK_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_bip,
    input  logic                              stall,
    input  logic                              halt,
    input  logic                              jmp,
    input  logic                              call,
    input  logic                              ret,
    input  logic [AB-1:0]                     jmp_addr,
    output logic [AB-1:0]                     Addr,
    output logic                              running,
    output logic                              halted,
    output logic                              stk_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0]  stk_level
);

    state_t        r_state;
    logic [AB-1:0] r_addr;
    logic          r_running;
    logic          r_halted;
    logic          r_err;

    cmd_t          w_cmd;
    logic [AB-1:0] w_ret_addr;
    logic [AB-1:0] w_top;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_cmd      = pick_cmd(halt, stall, ret, call, jmp);
    assign w_ret_addr = r_addr + AB'(1);
    assign w_push     = (r_state == ST_RUN) && (w_cmd == CMD_CALL) && !w_full;
    assign w_pop      = (r_state == ST_RUN) && (w_cmd == CMD_RET) && !w_empty;

    bip_return_stack #(
        .AB          (AB),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_ret_addr),
        .dout  (w_top),
        .level (stk_level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= RESET_ADDR;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_addr <= RESET_ADDR;
                    if (start_bip) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    unique case (w_cmd)
                        CMD_HALT: begin
                            r_state   <= ST_HALT;
                            r_running <= 1'b0;
                            r_halted  <= 1'b1;
                        end
                        CMD_STALL: ;
                        CMD_RET: begin
                            if (!w_empty) begin
                                r_addr <= w_top;
                            end else begin
                                r_err     <= 1'b1;
                                r_state   <= ST_HALT;
                                r_running <= 1'b0;
                                r_halted  <= 1'b1;
                            end
                        end
                        CMD_CALL: begin
                            if (!w_full) begin
                                r_addr <= jmp_addr;
                            end else begin
                                r_err     <= 1'b1;
                                r_state   <= ST_HALT;
                                r_running <= 1'b0;
                                r_halted  <= 1'b1;
                            end
                        end
                        CMD_JMP:  r_addr <= jmp_addr;
                        CMD_NEXT: r_addr <= w_ret_addr;
                        default:  ;
                    endcase
                end
                ST_HALT: ;
                default: begin
                    r_state   <= ST_IDLE;
                    r_addr    <= RESET_ADDR;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign Addr    = r_addr;
    assign running = r_running;
    assign halted  = r_halted;
    assign stk_err = r_err;

endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer: directed vector table from the test plan,
// then randomized commands checked against a queue-based reference model.
module tb_program_sequencer;

    localparam int AB    = 11;
    localparam int DEPTH = 4;
    localparam int AMOD  = 2048;

    // command bit order: {rst, start, stall, halt, jmp, call, ret}
    localparam bit [6:0] NO = 7'b0000000;
    localparam bit [6:0] R  = 7'b1000000;
    localparam bit [6:0] S  = 7'b0100000;
    localparam bit [6:0] ST = 7'b0010000;
    localparam bit [6:0] H  = 7'b0001000;
    localparam bit [6:0] J  = 7'b0000100;
    localparam bit [6:0] C  = 7'b0000010;
    localparam bit [6:0] RT = 7'b0000001;

    // expected flag order: {stk_err, running, halted}
    localparam bit [2:0] F_IDLE = 3'b000;
    localparam bit [2:0] F_RUN  = 3'b010;
    localparam bit [2:0] F_HLT  = 3'b001;
    localparam bit [2:0] F_ERR  = 3'b101;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_bip = 1'b0;
    logic          stall = 1'b0;
    logic          halt = 1'b0;
    logic          jmp = 1'b0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic [AB-1:0] jmp_addr = '0;
    logic [AB-1:0] Addr;
    logic          running;
    logic          halted;
    logic          stk_err;
    logic [2:0]    stk_level;

    always #5 clk = ~clk;

    program_sequencer #(
        .AB          (AB),
        .RESET_ADDR  (11'd0),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_bip (start_bip),
        .stall     (stall),
        .halt      (halt),
        .jmp       (jmp),
        .call      (call),
        .ret       (ret),
        .jmp_addr  (jmp_addr),
        .Addr      (Addr),
        .running   (running),
        .halted    (halted),
        .stk_err   (stk_err),
        .stk_level (stk_level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit [6:0] c, input int ja);
        {rst, start_bip, stall, halt, jmp, call, ret} = c;
        jmp_addr = AB'(ja);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit [6:0] c;
        int       ja;
        int       ea;
        int       el;
        bit [2:0] f;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit [6:0] c, int ja, int ea, int el, bit [2:0] f);
        vec_t v;
        v.c = c; v.ja = ja; v.ea = ea; v.el = el; v.f = f;
        return v;
    endfunction

    // reference model state
    int  m_mode;   // 0 idle, 1 run, 2 halt
    int  m_addr;
    int  m_stk[$];
    bit  m_err;

    task automatic model_step(input bit [6:0] c, input int ja);
        bit r_, s_, st_, h_, j_, cl_, rt_;
        {r_, s_, st_, h_, j_, cl_, rt_} = c;
        if (r_) begin
            m_mode = 0; m_addr = 0; m_err = 0; m_stk.delete();
        end else if (m_mode == 0) begin
            if (s_) m_mode = 1;
        end else if (m_mode == 1) begin
            if (h_) m_mode = 2;
            else if (st_) begin end
            else if (rt_) begin
                if (m_stk.size() > 0) m_addr = m_stk.pop_back();
                else begin m_err = 1; m_mode = 2; end
            end else if (cl_) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back((m_addr + 1) % AMOD);
                    m_addr = ja;
                end else begin
                    m_err = 1; m_mode = 2;
                end
            end else if (j_) m_addr = ja;
            else m_addr = (m_addr + 1) % AMOD;
        end
    endtask

    initial begin
        // start-up, counting, stall
        tbl.push_back(mk(R,  0, 0, 0, F_IDLE));
        tbl.push_back(mk(S,  0, 0, 0, F_RUN));
        tbl.push_back(mk(NO, 0, 1, 0, F_RUN));
        tbl.push_back(mk(NO, 0, 2, 0, F_RUN));
        tbl.push_back(mk(NO, 0, 3, 0, F_RUN));
        tbl.push_back(mk(NO, 0, 4, 0, F_RUN));
        tbl.push_back(mk(NO, 0, 5, 0, F_RUN));
        tbl.push_back(mk(ST, 0, 5, 0, F_RUN));
        tbl.push_back(mk(ST, 0, 5, 0, F_RUN));
        tbl.push_back(mk(ST, 0, 5, 0, F_RUN));
        tbl.push_back(mk(NO, 0, 6, 0, F_RUN));
        // single call/return
        tbl.push_back(mk(J,  10,  10,  0, F_RUN));
        tbl.push_back(mk(C,  100, 100, 1, F_RUN));
        tbl.push_back(mk(NO, 0,   101, 1, F_RUN));
        tbl.push_back(mk(NO, 0,   102, 1, F_RUN));
        tbl.push_back(mk(RT, 0,   11,  0, F_RUN));
        // nested calls and unwinding
        tbl.push_back(mk(J,  20,  20,  0, F_RUN));
        tbl.push_back(mk(C,  200, 200, 1, F_RUN));
        tbl.push_back(mk(C,  300, 300, 2, F_RUN));
        tbl.push_back(mk(C,  400, 400, 3, F_RUN));
        tbl.push_back(mk(C,  500, 500, 4, F_RUN));
        tbl.push_back(mk(RT, 0,   401, 3, F_RUN));
        tbl.push_back(mk(RT, 0,   301, 2, F_RUN));
        tbl.push_back(mk(RT, 0,   201, 1, F_RUN));
        tbl.push_back(mk(RT, 0,   21,  0, F_RUN));
        // overflow
        tbl.push_back(mk(C,  600, 600, 1, F_RUN));
        tbl.push_back(mk(C,  601, 601, 2, F_RUN));
        tbl.push_back(mk(C,  602, 602, 3, F_RUN));
        tbl.push_back(mk(C,  603, 603, 4, F_RUN));
        tbl.push_back(mk(C,  700, 603, 4, F_ERR));
        tbl.push_back(mk(S|J|C, 5, 603, 4, F_ERR));
        tbl.push_back(mk(R,  0,   0,   0, F_IDLE));
        // underflow, then HALT ignores everything but rst
        tbl.push_back(mk(S,  0,   0,   0, F_RUN));
        tbl.push_back(mk(RT, 0,   0,   0, F_ERR));
        tbl.push_back(mk(S,  9,   0,   0, F_ERR));
        tbl.push_back(mk(J,  9,   0,   0, F_ERR));
        tbl.push_back(mk(C,  9,   0,   0, F_ERR));
        tbl.push_back(mk(S|J, 9,  0,   0, F_ERR));
        tbl.push_back(mk(S|C, 9,  0,   0, F_ERR));
        tbl.push_back(mk(R,  0,   0,   0, F_IDLE));
        // address wrap
        tbl.push_back(mk(S,  0,    0,    0, F_RUN));
        tbl.push_back(mk(J,  2047, 2047, 0, F_RUN));
        tbl.push_back(mk(NO, 0,    0,    0, F_RUN));
        // same-cycle priority
        tbl.push_back(mk(J,  30, 30, 0, F_RUN));
        tbl.push_back(mk(H|J, 99, 30, 0, F_HLT));
        tbl.push_back(mk(R,  0,  0,  0, F_IDLE));
        tbl.push_back(mk(S,  0,  0,  0, F_RUN));
        tbl.push_back(mk(ST|C, 77, 0, 0, F_RUN));
        tbl.push_back(mk(J|C, 50, 50, 1, F_RUN));
        tbl.push_back(mk(RT, 0,  1,  0, F_RUN));
        // pushed return address wraps
        tbl.push_back(mk(J,  2047, 2047, 0, F_RUN));
        tbl.push_back(mk(C,  5,    5,    1, F_RUN));
        tbl.push_back(mk(RT, 0,    0,    0, F_RUN));
        // reset mid-call, IDLE ignores commands
        tbl.push_back(mk(C,  9,  9,  1, F_RUN));
        tbl.push_back(mk(R,  0,  0,  0, F_IDLE));
        tbl.push_back(mk(J,  44, 0,  0, F_IDLE));
        tbl.push_back(mk(C|ST, 44, 0, 0, F_IDLE));

        #2;
        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].ja);
            chk($sformatf("v%0d.addr", i), int'(Addr), tbl[i].ea);
            chk($sformatf("v%0d.level", i), int'(stk_level), tbl[i].el);
            chk($sformatf("v%0d.err", i), int'(stk_err), int'(tbl[i].f[2]));
            chk($sformatf("v%0d.running", i), int'(running), int'(tbl[i].f[1]));
            chk($sformatf("v%0d.halted", i), int'(halted), int'(tbl[i].f[0]));
        end

        // randomized run against the model
        drive(R, 0);
        model_step(R, 0);
        for (int k = 0; k < 4000; k++) begin
            bit [6:0] c;
            int ja;
            c[6] = ($urandom_range(0, 59) == 0);
            c[5] = ($urandom_range(0, 3) == 0);
            c[4] = ($urandom_range(0, 5) == 0);
            c[3] = ($urandom_range(0, 99) == 0);
            c[2] = ($urandom_range(0, 7) == 0);
            c[1] = ($urandom_range(0, 5) == 0);
            c[0] = ($urandom_range(0, 4) == 0);
            ja = ($urandom_range(0, 9) == 0) ? AMOD - 1 : int'($urandom_range(0, AMOD - 1));
            drive(c, ja);
            model_step(c, ja);
            chk($sformatf("r%0d.addr", k), int'(Addr), m_addr);
            chk($sformatf("r%0d.level", k), int'(stk_level), m_stk.size());
            chk($sformatf("r%0d.err", k), int'(stk_err), int'(m_err));
            chk($sformatf("r%0d.running", k), int'(running), int'(m_mode == 1));
            chk($sformatf("r%0d.halted", k), int'(halted), int'(m_mode == 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
